// File: rtl/common_pkg.sv
//==============================================================================
// Module      : common_pkg
// Description : Shared types for the decode stage: instruction, control word,
//               encoding class, ALU operation and the ID/EX pipeline record.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package common_pkg;

    localparam int C_XLEN = 32;
    localparam int C_RW   = 5;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instruction_t;

    typedef enum logic [2:0] {
        ENC_R, ENC_I, ENC_S, ENC_B, ENC_U, ENC_J, ENC_X
    } encoding_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
    } alu_op_t;

    typedef struct packed {
        encoding_t         encoding;
        alu_op_t           alu_op;
        logic              alu_src;
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
        logic              branch;
        logic              jump;
        logic [C_RW-1:0]   write_back_id;
    } control_t;

    typedef struct packed {
        logic [C_XLEN-1:0] pc;
        logic [C_XLEN-1:0] imm;
        control_t          control;
        logic [C_XLEN-1:0] read1;
        logic [C_XLEN-1:0] read2;
        logic [C_RW-1:0]   rs1;
        logic [C_RW-1:0]   rs2;
    } id_ex_t;

    // funct3 -> ALU op; alt selects SUB/SRA where funct7[5] distinguishes them
    function automatic alu_op_t alu_from_funct(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  alu_from_funct = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_from_funct = ALU_SLL;
            3'b010:  alu_from_funct = ALU_SLT;
            3'b011:  alu_from_funct = ALU_SLTU;
            3'b100:  alu_from_funct = ALU_XOR;
            3'b101:  alu_from_funct = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_from_funct = ALU_OR;
            default: alu_from_funct = ALU_AND;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/control.sv
//==============================================================================
// Module      : control
// Description : Opcode decoder producing the control word of an instruction.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module control
    import common_pkg::*;
(
    input  instruction_t instruction,
    output control_t     ctrl
);

    // Decode opcode into encoding class and datapath controls; unknown -> ENC_X
    always_comb begin
        ctrl          = '0;
        ctrl.encoding = ENC_X;
        ctrl.alu_op   = ALU_ADD;
        case (instruction.opcode)
            7'b0110011: begin
                ctrl.encoding  = ENC_R;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = alu_from_funct(instruction.funct3, instruction.funct7[5]);
            end
            7'b0010011: begin
                ctrl.encoding  = ENC_I;
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = alu_from_funct(instruction.funct3,
                                     (instruction.funct3 == 3'b101) && instruction.funct7[5]);
            end
            7'b0000011: begin
                ctrl.encoding  = ENC_I;
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_read  = 1'b1;
            end
            7'b0100011: begin
                ctrl.encoding  = ENC_S;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            7'b1100011: begin
                ctrl.encoding  = ENC_B;
                ctrl.branch    = 1'b1;
                ctrl.alu_op    = ALU_SUB;
            end
            7'b0110111: begin
                ctrl.encoding  = ENC_U;
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_PASS_B;
            end
            7'b0010111: begin
                ctrl.encoding  = ENC_U;
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            7'b1101111: begin
                ctrl.encoding  = ENC_J;
                ctrl.reg_write = 1'b1;
                ctrl.jump      = 1'b1;
            end
            7'b1100111: begin
                ctrl.encoding  = ENC_I;
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.jump      = 1'b1;
            end
            default: ;
        endcase
        ctrl.write_back_id = ctrl.reg_write ? instruction.rd : '0;
    end

endmodule

`default_nettype wire

// File: rtl/imm_gen.sv
//==============================================================================
// Module      : imm_gen
// Description : Immediate extraction and sign extension by encoding class.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module imm_gen
    import common_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  instruction_t    instruction,
    input  encoding_t       encoding,
    output logic [XLEN-1:0] imm
);

    logic [31:0] ins;
    logic [31:0] imm32;

    assign ins = instruction;

    // Reassemble the scattered immediate bits; R/unknown carry no immediate
    always_comb begin
        imm32 = '0;
        case (encoding)
            ENC_I:   imm32 = {{20{ins[31]}}, ins[31:20]};
            ENC_S:   imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            ENC_B:   imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            ENC_U:   imm32 = {ins[31:12], 12'b0};
            ENC_J:   imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

`default_nettype wire

// File: rtl/regfile_bypass.sv
//==============================================================================
// Module      : regfile_bypass
// Description : Register file, 1 sync write port, 2 comb read ports with
//               same-cycle write-data bypass; x0 hard-wired to zero.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module regfile_bypass #(
    parameter int              XLEN      = 32,
    parameter int              REG_COUNT = 32,
    parameter logic [XLEN-1:0] SP_RESET  = 32'h0000_1000,
    localparam int             RW        = $clog2(REG_COUNT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [RW-1:0]   wr_id,
    input  logic [XLEN-1:0] wr_data,
    input  logic [RW-1:0]   rd_id1,
    input  logic [RW-1:0]   rd_id2,
    output logic [XLEN-1:0] rd_data1,
    output logic [XLEN-1:0] rd_data2
);

    logic [XLEN-1:0] regs [REG_COUNT];

    // Reset clears everything except the stack pointer; x0 is never written
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= (i == 2) ? SP_RESET : '0;
            end
        end else if (we && (wr_id != '0)) begin
            regs[wr_id] <= wr_data;
        end
    end

    // Reads see the write in flight this cycle so no write-back gap exists
    always_comb begin
        rd_data1 = regs[rd_id1];
        rd_data2 = regs[rd_id2];
        if (we && (wr_id == rd_id1)) rd_data1 = wr_data;
        if (we && (wr_id == rd_id2)) rd_data2 = wr_data;
        if (rd_id1 == '0) rd_data1 = '0;
        if (rd_id2 == '0) rd_data2 = '0;
    end

endmodule

`default_nettype wire

// File: rtl/decode_stage_pipelined.sv
//==============================================================================
// Module      : decode_stage_pipelined
// Description : Decode stage with registered ID/EX output, valid/ready
//               handshake, load-use bubble insertion, flush and WB bypass.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module decode_stage_pipelined
    import common_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              REG_COUNT = 32,
    parameter logic [XLEN-1:0] SP_RESET  = 32'h0000_1000,
    localparam int             RW        = $clog2(REG_COUNT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  instruction_t    instruction,
    input  logic [XLEN-1:0] pc,
    input  logic            wb_reg_write,
    input  logic [RW-1:0]   wb_id,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output control_t        out_control,
    output logic [XLEN-1:0] out_read1,
    output logic [XLEN-1:0] out_read2,
    output logic [RW-1:0]   out_rs1,
    output logic [RW-1:0]   out_rs2
);

    control_t        dec_ctrl;
    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] dec_read1;
    logic [XLEN-1:0] dec_read2;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            advance;
    logic            hazard;
    id_ex_t          id_ex;
    logic            id_ex_valid;

    assign rs1 = RW'(instruction.rs1);
    assign rs2 = RW'(instruction.rs2);

    control u_control (
        .instruction (instruction),
        .ctrl        (dec_ctrl)
    );

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instruction (instruction),
        .encoding    (dec_ctrl.encoding),
        .imm         (dec_imm)
    );

    regfile_bypass #(
        .XLEN      (XLEN),
        .REG_COUNT (REG_COUNT),
        .SP_RESET  (SP_RESET)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (wb_reg_write),
        .wr_id    (wb_id),
        .wr_data  (wb_data),
        .rd_id1   (rs1),
        .rd_id2   (rs2),
        .rd_data1 (dec_read1),
        .rd_data2 (dec_read2)
    );

    // Load in ID/EX whose destination feeds an operand of the incoming instruction
    always_comb begin
        uses_rs1 = dec_ctrl.encoding inside {ENC_R, ENC_I, ENC_S, ENC_B};
        uses_rs2 = dec_ctrl.encoding inside {ENC_R, ENC_S, ENC_B};
        advance  = !id_ex_valid || out_ready;
        hazard   = in_valid && id_ex_valid && id_ex.control.mem_read &&
                   (id_ex.control.write_back_id != '0) &&
                   ((uses_rs1 && (id_ex.control.write_back_id == rs1)) ||
                    (uses_rs2 && (id_ex.control.write_back_id == rs2)));
        in_ready = flush || (advance && !hazard);
    end

    // ID/EX register: reset > flush > hazard bubble > advance > hold
    always_ff @(posedge clk) begin
        if (!rst) begin
            id_ex_valid <= 1'b0;
            id_ex       <= '0;
        end else if (flush) begin
            id_ex_valid <= 1'b0;
        end else if (advance) begin
            if (hazard) begin
                id_ex_valid <= 1'b0;
            end else begin
                id_ex_valid   <= in_valid;
                id_ex.pc      <= pc;
                id_ex.imm     <= dec_imm;
                id_ex.control <= dec_ctrl;
                id_ex.read1   <= dec_read1;
                id_ex.read2   <= dec_read2;
                id_ex.rs1     <= rs1;
                id_ex.rs2     <= rs2;
            end
        end
    end

    assign out_valid   = id_ex_valid;
    assign out_pc      = id_ex.pc;
    assign out_imm     = id_ex.imm;
    assign out_control = id_ex.control;
    assign out_read1   = id_ex.read1;
    assign out_read2   = id_ex.read2;
    assign out_rs1     = id_ex.rs1;
    assign out_rs2     = id_ex.rs2;

endmodule

`default_nettype wire
